aes_round_sequencer: RTL and testbench



---
 rtl/aes_ctrl_pkg.sv | 26 ++
 rtl/aes_wait_counter.sv | 38 +++
 rtl/aes_round_sequencer.sv | 151 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption control path.
// Step encoding is also used by the datapath step mux.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP_ARK = 2'b00,
    STEP_ISR = 2'b01,
    STEP_ISB = 2'b10,
    STEP_IMC = 2'b11
  } step_t;

  typedef enum logic [2:0] {
    IDLE,
    KEYWAIT,
    LOAD,
    ARK,
    ISR,
    ISB,
    IMC,
    DONE
  } seq_state_t;

  localparam int AES_NR     = 10;
  localparam int AES_NWORDS = 4;

endpackage

// File: rtl/aes_wait_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Shared by the key-expansion wait and the InvSubBytes latency wait.
module aes_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the AES-128 decryption datapath: load, round steps,
// and the AES_START/AES_DONE handshake. Outputs decode registered state.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int KEY_WAIT_CYC = 12,
  parameter int SUB_LAT      = 2,
  parameter int NR           = AES_NR
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       LOAD_MSG,
  output logic       STATE_WE,
  output logic [1:0] STEP,
  output logic [1:0] WORD_SL,
  output logic [3:0] ROUND
);

  localparam int CMAX = (KEY_WAIT_CYC > SUB_LAT) ? KEY_WAIT_CYC : SUB_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  seq_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] word_q, word_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_dec;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  logic  we;
  logic  load_msg;
  logic  done;
  logic  busy;
  step_t step;

  aes_wait_counter #(
    .W(CW)
  ) u_wait (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    word_d   = word_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    we       = 1'b0;
    load_msg = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    step     = STEP_ARK;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (AES_START) begin
          state_d  = KEYWAIT;
          cnt_load = 1'b1;
          cnt_val  = CW'(KEY_WAIT_CYC - 1);
          round_d  = '0;
          word_d   = '0;
        end
      end
      KEYWAIT: begin
        if (cnt_zero) state_d = LOAD;
        else          cnt_dec = 1'b1;
      end
      LOAD: begin
        load_msg = 1'b1;
        we       = 1'b1;
        round_d  = '0;
        state_d  = ARK;
      end
      ARK: begin
        we = 1'b1;
        if (round_q == 4'(NR)) begin
          state_d = DONE;
        end else if (round_q == '0) begin
          state_d = ISR;
        end else begin
          state_d = IMC;
          word_d  = '0;
        end
      end
      ISR: begin
        we       = 1'b1;
        step     = STEP_ISR;
        cnt_load = 1'b1;
        cnt_val  = CW'(SUB_LAT - 1);
        state_d  = ISB;
      end
      ISB: begin
        if (cnt_zero) begin
          we      = 1'b1;
          step    = STEP_ISB;
          round_d = round_q + 4'd1;
          state_d = ARK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IMC: begin
        we     = 1'b1;
        step   = STEP_IMC;
        word_d = word_q + 2'd1;
        if (word_q == 2'(AES_NWORDS - 1)) state_d = ISR;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!AES_START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Dropping the request aborts any active run; outputs stay Moore.
    if (busy && !AES_START) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      round_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      word_q  <= word_d;
    end
  end

  assign AES_DONE = done;
  assign BUSY     = busy;
  assign LOAD_MSG = load_msg;
  assign STATE_WE = we;
  assign STEP     = step;
  assign WORD_SL  = (state_q == IMC) ? word_q : 2'b00;
  assign ROUND    = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: per-cycle script built from the round
// schedule, with randomized hold, abort and async-reset points.
module tb_aes_round_sequencer;

  localparam int KW  = 12;
  localparam int SL  = 2;
  localparam int NRR = 10;
  localparam int EXP_LEN = KW + 2 + (NRR - 1) * (SL + 6) + (SL + 2);
  localparam int WE_EXP  = 1 + 1 + (NRR - 1) * 7 + 3;

  logic       CLK;
  logic       RESET_N;
  logic       AES_START;
  logic       AES_DONE;
  logic       BUSY;
  logic       LOAD_MSG;
  logic       STATE_WE;
  logic [1:0] STEP;
  logic [1:0] WORD_SL;
  logic [3:0] ROUND;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic       lm;
    logic       we;
    logic [1:0] step;
    logic [1:0] word;
    logic       rchk;
    logic [3:0] round;
  } ev_t;

  ev_t exp_q[$];
  int  isb_idx[$];

  aes_round_sequencer #(
    .KEY_WAIT_CYC(KW),
    .SUB_LAT     (SL),
    .NR          (NRR)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .AES_START(AES_START),
    .AES_DONE (AES_DONE),
    .BUSY     (BUSY),
    .LOAD_MSG (LOAD_MSG),
    .STATE_WE (STATE_WE),
    .STEP     (STEP),
    .WORD_SL  (WORD_SL),
    .ROUND    (ROUND)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input logic done, busy, lm, we,
                             input logic [1:0] step, word,
                             input logic rchk, input int rnd);
    ev_t e;
    e.done  = done;
    e.busy  = busy;
    e.lm    = lm;
    e.we    = we;
    e.step  = step;
    e.word  = word;
    e.rchk  = rchk;
    e.round = rchk ? 4'(rnd) : 4'd0;
    return e;
  endfunction

  function automatic logic [31:0] enc(input ev_t e);
    return {19'd0, e.done, e.busy, e.lm, e.we, e.step, e.word, e.round};
  endfunction

  function automatic logic [31:0] obs(input logic rchk);
    return {19'd0, AES_DONE, BUSY, LOAD_MSG, STATE_WE, STEP, WORD_SL,
            rchk ? ROUND : 4'd0};
  endfunction

  // Schedule: key wait, load, ARK(0), then ISR/ISB/ARK(r)[/IMC x4].
  task automatic build_script();
    exp_q.delete();
    isb_idx.delete();
    for (int i = 0; i < KW; i++) exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 1, 2'b00, 2'b00, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 1, 2'b00, 2'b00, 1, 0));
    for (int r = 1; r <= NRR; r++) begin
      exp_q.push_back(mk(0, 1, 0, 1, 2'b01, 2'b00, 0, 0));
      for (int s = 0; s < SL - 1; s++) begin
        isb_idx.push_back(exp_q.size());
        exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      end
      isb_idx.push_back(exp_q.size());
      exp_q.push_back(mk(0, 1, 0, 1, 2'b10, 2'b00, 0, 0));
      exp_q.push_back(mk(0, 1, 0, 1, 2'b00, 2'b00, 1, r));
      if (r < NRR)
        for (int w = 0; w < 4; w++)
          exp_q.push_back(mk(0, 1, 0, 1, 2'b11, 2'(w), 0, 0));
    end
    exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
  endtask

  // Caller raises AES_START at a negedge; index 0 is the sample after the
  // edge that sees it. Returns early on abort or reset injection.
  task automatic run_check(input int abort_at, input int rst_at);
    int   we_cnt;
    int   lm_at;
    int   done_at;
    ev_t  e;
    we_cnt  = 0;
    lm_at   = -1;
    done_at = -1;
    for (int i = 0; i <= EXP_LEN; i++) begin
      @(negedge CLK);
      e = exp_q[i];
      chk($sformatf("seq%0d", i), obs(e.rchk), enc(e));
      if (STATE_WE) we_cnt++;
      if (LOAD_MSG && lm_at < 0) lm_at = i;
      if (AES_DONE && done_at < 0) done_at = i;
      if (i == abort_at) begin
        AES_START = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge CLK);
          chk($sformatf("abort_idle%0d", k), obs(1'b0), 32'd0);
        end
        return;
      end
      if (i == rst_at) begin
        #1 RESET_N = 1'b0;
        #1 chk("rst_async", obs(1'b1), 32'd0);
        #1 RESET_N = 1'b1;
        return;
      end
    end
    chk("we_pulses", 32'(we_cnt), 32'(WE_EXP));
    chk("load_cyc", 32'(lm_at), 32'(KW));
    chk("done_cyc", 32'(done_at), 32'(EXP_LEN));
  endtask

  task automatic finish_handshake();
    int hold;
    hold = $urandom_range(1, 5);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      chk("done_hold", obs(1'b0), enc(exp_q[EXP_LEN]));
    end
    AES_START = 1'b0;
    @(negedge CLK);
    chk("done_clear", obs(1'b0), 32'd0);
  endtask

  initial begin
    int ab;
    int rs;
    n_chk     = 0;
    n_fail    = 0;
    RESET_N   = 1'b0;
    AES_START = 1'b0;
    build_script();
    #1 chk("reset_vals", obs(1'b1), 32'd0);
    @(negedge CLK);
    chk("reset_hold", obs(1'b1), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle", obs(1'b1), 32'd0);

    AES_START = 1'b1;
    run_check(-1, -1);
    finish_handshake();

    repeat ($urandom_range(1, 3)) @(negedge CLK);
    AES_START = 1'b1;
    run_check(40, -1);
    AES_START = 1'b1;
    run_check(-1, -1);
    finish_handshake();

    ab = $urandom_range(0, EXP_LEN - 1);
    @(negedge CLK);
    AES_START = 1'b1;
    run_check(ab, -1);
    @(negedge CLK);
    AES_START = 1'b1;
    run_check(-1, -1);
    finish_handshake();

    rs = isb_idx[$urandom_range(0, isb_idx.size() - 1)];
    @(negedge CLK);
    AES_START = 1'b1;
    run_check(-1, rs);
    run_check(-1, -1);
    finish_handshake();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
